// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way request arbiter: round-robin by default, fixed CPU priority when
// MEM_ARB_CPU_PRIO_EN is defined.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

`ifdef MEM_ARB_CPU_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[OWN_CPU]) begin
      gnt_o[OWN_CPU] = 1'b1;
    end else if (req_i[OWN_LDR]) begin
      gnt_o[OWN_LDR] = 1'b1;
    end
  end
`else
  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt_o = 2'b00;
    if (&req_i) begin
      gnt_o[~last_i] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and loader accesses onto one memory port with registered
// read data and a one-cycle ready pulse. Define MEM_ARB_CPU_PRIO_EN for fixed CPU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic             last_q, last_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]    ldr_rdata_q, ldr_rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic             ldr_ready_q, ldr_ready_d;
  logic [1:0]       gnt;
  logic             gnt_ldr;
  logic             sel_we;

  mem_arb_rr2 u_rr2 (
    .req_i  ({ldr_req, cpu_req}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign gnt_ldr = gnt[OWN_LDR];
  assign sel_we  = gnt_ldr ? ldr_we : cpu_we;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    cpu_ready_d = 1'b0;
    ldr_ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d  = ACC;
          owner_d  = gnt_ldr;
          last_d   = gnt_ldr;
          we_d     = sel_we;
          addr_d   = gnt_ldr ? ldr_addr : cpu_addr;
          wdata_d  = gnt_ldr ? ldr_wdata : cpu_wdata;
          mem_en_d = 1'b1;
          mem_we_d = sel_we;
        end
      end
      ACC: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        // Final wait cycle: memory data is valid now, ready goes out next cycle.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          if (owner_q == OWN_LDR) begin
            ldr_ready_d = 1'b1;
            if (!we_q) ldr_rdata_d = mem_rdata;
          end else begin
            cpu_ready_d = 1'b1;
            if (!we_q) cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      last_q      <= OWN_LDR;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      ldr_ready_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      we_q        <= we_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      cpu_ready_q <= cpu_ready_d;
      ldr_ready_q <= ldr_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign ldr_ready = ldr_ready_q;
  assign cpu_stall = cpu_req & ~cpu_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-accurate memory model.
module tb_mem_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned MEM_LAT = 3;
  localparam int unsigned P       = MEM_LAT + 3;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready, cpu_stall;
  logic          ldr_req = 1'b0, ldr_we = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic [DW-1:0] ldr_rdata;
  logic          ldr_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_stall (cpu_stall),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_rdata (ldr_rdata),
    .ldr_ready (ldr_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Initial memory contents, shared by the device model and the expectations.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory device: writes on mem_en, read data valid MEM_LAT cycles later.
  logic [31:0] dev_mem [logic [31:0]];
  logic        pipe_v [MEM_LAT] = '{default: 1'b0};
  logic [31:0] pipe_d [MEM_LAT] = '{default: 32'h0};

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    for (int k = MEM_LAT - 1; k > 0; k--) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_d[k] <= pipe_d[k-1];
    end
    pipe_v[0] <= mem_en & ~mem_we;
    pipe_d[0] <= dev_rd(mem_addr);
    if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
  end

  assign mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 32'hBAD0_BAD0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_cpu_rd = '0;
  logic [31:0] exp_ldr_rd = '0;
  logic        rr_chk = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic push(input logic own, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    exp_t e;
    e.own = own; e.we = we; e.addr = addr; e.wdata = wdata;
    if (we) begin
      e.rdata = own ? exp_ldr_rd : exp_cpu_rd;
      ref_mem[addr] = wdata;
    end else begin
      e.rdata = ref_rd(addr);
      if (own) exp_ldr_rd = e.rdata;
      else     exp_cpu_rd = e.rdata;
    end
    sb_q.push_back(e);
  endtask

  // Checks every memory strobe and ready pulse against the scoreboard.
  task automatic monitor();
    int   en_cyc = 0;
    int   prev_en = 0;
    logic have_prev = 1'b0;
    logic prev_mem_en = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rr_chk) have_prev = 1'b0;
      if (mem_en) begin
        chk("en_single", prev_mem_en, 1'b0);
        if (sb_q.size() == 0) begin
          chk("en_spurious", mem_en, 1'b0);
        end else begin
          chk("mem_we", mem_we, sb_q[0].we);
          chk("mem_addr", mem_addr, sb_q[0].addr);
          if (sb_q[0].we) chk("mem_wdata", mem_wdata, sb_q[0].wdata);
        end
        if (rr_chk && have_prev) chk("grant_gap", 32'(cyc - prev_en), P);
        have_prev = rr_chk;
        prev_en = cyc;
        en_cyc = cyc;
      end
      if (cpu_ready || ldr_ready) begin
        chk("one_ready", cpu_ready & ldr_ready, 1'b0);
        if (sb_q.size() == 0) begin
          chk("rdy_spurious", cpu_ready | ldr_ready, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("owner", ldr_ready, e.own);
          chk("latency", 32'(cyc - en_cyc), MEM_LAT + 1);
          chk("rdata", e.own ? ldr_rdata : cpu_rdata, e.rdata);
        end
      end
      prev_mem_en = mem_en;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, mem_en, 1'b0);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_rdy"}, {cpu_ready, ldr_ready}, 2'b00);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_crd"}, cpu_rdata, 32'h0);
    chk({tag, "_lrd"}, ldr_rdata, 32'h0);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    #1;
    chk_zero("rst");
    sb_q.delete();
    exp_cpu_rd = '0;
    exp_ldr_rd = '0;
    tick();
    tick();
    clr_n = 1'b1;
  endtask

  // One access from an idle arbiter; called at cycle 0 just after the edge.
  task automatic do_access(input logic own, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic chg, input logic drop);
    if (own) begin
      ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    push(own, we, addr, wdata);
    for (int i = 0; i <= int'(MEM_LAT) + 2; i++) begin
      if (i == 1 && chg) begin
        if (own) ldr_addr = addr + 32'h10;
        else     cpu_addr = addr + 32'h10;
      end
      if (i == 1 && drop) begin
        if (own) ldr_req = 1'b0;
        else     cpu_req = 1'b0;
      end
      @(negedge clk);
      chk("ready_t", own ? ldr_ready : cpu_ready, i == int'(MEM_LAT) + 2);
      chk("en_t", mem_en, i == 1);
      if (!own) chk("stall_t", cpu_stall, (i < int'(MEM_LAT) + 2) && !(drop && i >= 1));
      tick();
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_en", mem_en, 1'b0);
      chk("idle_rdy", cpu_ready | ldr_ready, 1'b0);
      tick();
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    do_reset();
    chk("rst_stall", cpu_stall, 1'b0);

    // Reads, writes, mid-access address change, dropped request.
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    chk("cpu_rd_hold", cpu_rdata, 32'hDEAD_BEEF);
    do_access(1'b1, 1'b1, 32'h40, 32'h1234, 1'b0, 1'b0);
    chk("ldr_rd_kept", ldr_rdata, 32'h0);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    do_access(1'b0, 1'b1, 32'h20, 32'h5555_AAAA, 1'b0, 1'b0);
    chk("cpu_rd_kept", cpu_rdata, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    do_access(1'b0, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1);
    idle_chk(5);

    // Both requesters held continuously from reset.
    do_reset();
    cpu_we = 1'b0; cpu_addr = 32'h100; cpu_req = 1'b1;
    ldr_we = 1'b0; ldr_addr = 32'h200; ldr_req = 1'b1;
`ifdef MEM_ARB_CPU_PRIO_EN
    for (int k = 0; k < 4; k++) push(1'b0, 1'b0, 32'h100, 32'h0);
`else
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(1'b0, 1'b0, 32'h100, 32'h0);
      else            push(1'b1, 1'b0, 32'h200, 32'h0);
    end
`endif
    rr_chk = 1'b1;
    repeat (3 * P + MEM_LAT + 3) tick();
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    rr_chk = 1'b0;
    chk("rr_drained", 32'(sb_q.size()), 32'd0);
    idle_chk(3);

    // Reset during WAIT aborts the access.
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0);
    cpu_we = 1'b0; cpu_addr = 32'h50; cpu_req = 1'b1;
    push(1'b0, 1'b0, 32'h50, 32'h0);
    tick();
    tick();
    chk("pre_rst_crd", cpu_rdata, 32'hA5A5_0100);
    do_reset();
    idle_chk(int'(MEM_LAT) + 4);

    do_access(1'b0, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0);
    chk("final_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified memory of the multicycle CPU between two requesters: the CPU (fetch and load/store states) and a program loader/debug port.
- Serialises accesses and registers read data.
- Returns a one-cycle ready pulse to the selected requester.
- Drives cpu_stall so the main decoder holds its state while a CPU access is pending.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 1, memory read latency in cycles after the mem_en cycle; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ready.
- cpu_we  in  1  CPU write enable (1 = write).
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data to CPU.
- cpu_ready  out  1  one-cycle completion pulse to CPU.
- cpu_stall  out  1  cpu_req & ~cpu_ready; freezes the CPU FSM.
- ldr_req  in  1  loader request; held high until ldr_ready.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_rdata  out  DW  read data to loader.
- ldr_ready  out  1  one-cycle completion pulse to loader.
- mem_en  out  1  memory access strobe, exactly one cycle per access.
- mem_we  out  1  memory write enable, valid with mem_en.
- mem_addr  out  AW  memory address, valid with mem_en.
- mem_wdata  out  DW  memory write data, valid with mem_en.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (clr_n low, asynchronous):
  - State goes to IDLE.
  - mem_en, mem_we, cpu_ready and ldr_ready = 0.
  - mem_addr, mem_wdata, cpu_rdata and ldr_rdata = 0.
  - Wait counter = 0; last-grant pointer = LDR, so the CPU wins the first tie.
- Reset mid-access aborts the access; no ready pulse follows.
- State machine: IDLE -> ACC -> WAIT -> RESP -> IDLE.
  - IDLE: sample requests. If any is present, latch owner, we, addr and wdata into registers, then go to ACC.
  - ACC (1 cycle): mem_en = 1 and mem_we/mem_addr/mem_wdata driven from the latched registers. Load the counter with MEM_LAT.
  - WAIT (MEM_LAT cycles): decrement the counter. At the edge ending the last WAIT cycle:
    - On a read, capture mem_rdata into the owner's rdata register.
    - On a write, rdata holds its previous value.
  - RESP (1 cycle): owner's ready = 1; then go to IDLE.
- Latency: request first sampled in IDLE at cycle 0 -> mem_en in cycle 1 -> ready in cycle MEM_LAT+2.
- Throughput: one access per MEM_LAT+3 cycles.
- Arbitration (round-robin):
  - With both requests high in IDLE, grant the requester not equal to last-grant.
  - With one request high, grant it.
  - Update last-grant on each grant.
- Handshake rules:
  - Inputs are latched at grant; later changes to addr/we/wdata are ignored.
  - If a requester drops req mid-access, the access still completes and the ready pulse is still issued.
  - req high in the cycle after ready counts as a new request.
- rdata registers hold their value until the next read completion for that requester.
- Only one ready is high in any cycle. cpu_ready and ldr_ready are never high together.
- mem_en is never high outside ACC.

Optional Feature:
- Macro MEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. The CPU always wins simultaneous requests, and the last-grant pointer is unused.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding: IDLE=2'd0, ACC=2'd1, WAIT=2'd2, RESP=2'd3.
  - Owner IDs: OWN_CPU=1'b0, OWN_LDR=1'b1.
- One sub-module, mem_arb_rr2: a 2-way arbiter.
  - Inputs: req[1:0], last-grant pointer.
  - Output: one-hot grant.
  - Contains the MEM_ARB_CPU_PRIO_EN choice.
- FSM, latch registers and counter stay in mem_arbiter.

Test Plan:
1. CPU read, MEM_LAT=1: cpu_req=1, cpu_we=0, addr=0x10, memory returns 0xDEADBEEF -> mem_en high in cycle 1 with addr 0x10; cpu_ready pulse in cycle 3; cpu_rdata=0xDEADBEEF; cpu_stall high in cycles 0-2.
2. Loader write, MEM_LAT=3: ldr_we=1, addr=0x40, wdata=0x1234 -> mem_we=1 with mem_en in cycle 1 and wdata 0x1234; ldr_ready in cycle 5; ldr_rdata unchanged.
3. Simultaneous requests held continuously after reset:
   - Round-robin build: grant order CPU, LDR, CPU, LDR; each grant MEM_LAT+3 cycles apart; never two readies in one cycle.
   - With MEM_ARB_CPU_PRIO_EN: CPU granted every time while cpu_req stays high.
4. Input change mid-access: CPU changes addr from 0x10 to 0x20 in cycle 1 -> mem_addr stays 0x10; completion unaffected.
5. Reset mid-access: clr_n low during WAIT -> mem_en, readies and rdata = 0 immediately; state IDLE; no ready pulse after clr_n rises.
6. Dropped request: CPU drops req in ACC -> cpu_ready still pulses in cycle MEM_LAT+2; next access starts only on a new req.
